// File: rtl/sda_link_pkg.sv
// Shared definitions for the scl/sda link (receiver sda_to_par and its transmitter).
package sda_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_STOP
  } state_e;

  localparam int unsigned NBITS_DEFAULT = 4;

  // Both link wires idle high.
  localparam logic BUS_IDLE = 1'b1;

endpackage

// File: rtl/sda_to_par_sync_edge.sv
// sync_edge: SYNC_STAGES synchronizer, history flop and registered rise/fall strobes.
// lvl is the history-flop value, time-aligned with the rise/fall strobes.
module sync_edge
  import sda_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the pin through the synchronizer and compare newest value with history.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  // Synchronizer and history reset to the idle bus level so reset release is silent.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{BUS_IDLE}};
      hist_q <= BUS_IDLE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = hist_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sda_to_par.sv
// sda_to_par: scl/sda serial-to-parallel receiver, start/stop framed, MSB first.
// Optional feature macro: DECODE16_EN (registered one-hot decode of data on out16).
module sda_to_par
  import sda_link_pkg::*;
#(
  parameter int unsigned NBITS       = NBITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                scl,
  input  logic                sda,
  output logic [NBITS-1:0]    data,
  output logic                valid,
  output logic                frame_err,
  output logic                busy,
  output logic [2**NBITS-1:0] out16
);

  localparam int unsigned CW = $clog2(NBITS + 1);

  logic scl_lvl, scl_rise, scl_fall_unused;
  logic sda_lvl, sda_rise, sda_fall;
  logic bit_det, start_det, stop_det;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .sclk (sclk),
    .rst  (rst),
    .d    (scl),
    .lvl  (scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .sclk (sclk),
    .rst  (rst),
    .d    (sda),
    .lvl  (sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  // A coincident scl rise suppresses start/stop so only one event acts per cycle.
  assign bit_det   = scl_rise;
  assign start_det = sda_fall & scl_lvl & ~bit_det;
  assign stop_det  = sda_rise & scl_lvl & ~bit_det;

  // Frame sequencing: next state, shift register, counter and output strobes.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (bit_det) begin
          shreg_d = {shreg_q[NBITS-2:0], sda_lvl};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NBITS - 1)) state_d = WAIT_STOP;
        end else if (stop_det) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (start_det) begin
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_STOP: begin
        if (stop_det) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (bit_det) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (start_det) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Frame state and registered outputs.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

`ifdef DECODE16_EN
  logic [2**NBITS-1:0] out16_q, out16_d;

  // One-hot of the accepted word, loaded together with data.
  always_comb begin
    out16_d = out16_q;
    if (valid_d) begin
      out16_d         = '0;
      out16_d[data_d] = 1'b1;
    end
  end

  // Decode register.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) out16_q <= '0;
    else      out16_q <= out16_d;
  end

  assign out16 = out16_q;
`else
  assign out16 = '0;
`endif

endmodule

// File: tb/tb_sda_to_par.sv
// Self-checking bench for sda_to_par: link-level driver, frame-rule model, scoreboard monitor.
module tb_sda_to_par;
  import sda_link_pkg::*;

  localparam int unsigned NB   = 4;
  localparam int unsigned SYNC = 2;
  localparam int          LAT  = SYNC + 2;

  logic sclk = 1'b0;
  logic rst  = 1'b0;
  logic scl  = 1'b1;
  logic sda  = 1'b1;
  logic [NB-1:0]    data;
  logic             valid, frame_err, busy;
  logic [2**NB-1:0] out16;

  sda_to_par #(.NBITS(NB), .SYNC_STAGES(SYNC)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .out16     (out16)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned word;
    int          due;
  } exp_t;

  exp_t        vq[$];
  int          eq[$];
  bit          open = 1'b0;
  int          bits[$];
  int unsigned last_word = 0;
  bit          have_good = 1'b0;
  int          gap = 8;
  int          ev_cyc = 0;

  function automatic void check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model: frame rules over link events ----------------
  function automatic int unsigned frame_word();
    int unsigned w = 0;
    foreach (bits[i]) w = w * 2 + bits[i];
    return w;
  endfunction

  function automatic void push_err(input int c);
    eq.push_back(c + LAT);
  endfunction

  function automatic void m_start(input int c);
    if (open) push_err(c);
    open = 1'b1;
    bits.delete();
  endfunction

  function automatic void m_bit(input int b, input int c);
    if (open) begin
      bits.push_back(b);
      if (bits.size() > NB) begin
        push_err(c);
        open = 1'b0;
      end
    end
  endfunction

  function automatic void m_stop(input int c);
    exp_t e;
    if (open) begin
      if (bits.size() == NB) begin
        e.word = frame_word();
        e.due  = c + LAT;
        vq.push_back(e);
      end else begin
        push_err(c);
      end
      open = 1'b0;
    end
  endfunction

  function automatic logic [2**NB-1:0] exp16();
    logic [2**NB-1:0] v = '0;
`ifdef DECODE16_EN
    if (have_good) v[last_word[NB-1:0]] = 1'b1;
`endif
    return v;
  endfunction

  // ---------------- link driver ----------------
  task automatic pin(input logic s, input logic d);
    @(negedge sclk);
    scl    = s;
    sda    = d;
    ev_cyc = cyc;
  endtask

  task automatic hold();
    repeat (gap) @(posedge sclk);
  endtask

  task automatic busy_chk();
    if (gap >= 6) check("busy", busy, open);
  endtask

  task automatic ev_bit(input int b);
    if (scl) begin pin(1'b0, sda); hold(); end
    pin(1'b0, b[0]); hold();
    pin(1'b1, b[0]);
    m_bit(b, ev_cyc);
    hold();
    busy_chk();
  endtask

  task automatic ev_start();
    pin(1'b1, 1'b0);
    m_start(ev_cyc);
    hold();
    busy_chk();
  endtask

  task automatic ev_stop();
    pin(1'b1, 1'b1);
    m_stop(ev_cyc);
    hold();
    busy_chk();
  endtask

  task automatic send_bits(input int unsigned w, input int n);
    for (int i = n - 1; i >= 0; i--) ev_bit(int'((w >> i) & 1));
  endtask

  task automatic check_reset_outputs();
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_out16", out16, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge sclk) begin
    exp_t e;
    int   d;
    #1;
    if (rst) begin
      if (valid) begin
        if (vq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = vq.pop_front();
          check("valid_cycle", cyc, e.due);
          check("valid_data", data, e.word);
          last_word = e.word;
          have_good = 1'b1;
        end
      end else begin
        check("data_hold", data, last_word);
      end
      check("out16", out16, exp16());
      if (frame_err) begin
        if (eq.size() == 0) begin
          check("unexpected_frame_err", 1, 0);
        end else begin
          d = eq.pop_front();
          check("frame_err_cycle", cyc, d);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(posedge sclk);
    #1 check_reset_outputs();
    @(negedge sclk) rst = 1'b1;
    repeat (10) @(posedge sclk);
    #1 check_reset_outputs();

    // good frame ending in a 0 bit so the stop follows directly
    ev_start(); send_bits(4'b1010, 4); ev_stop();
    // short frame: stop after two bits
    ev_start(); send_bits(2'b10, 2); ev_stop();
    // long frame: fifth bit aborts, trailing stop ignored
    ev_start(); send_bits(5'b10110, 5); ev_stop();
    // back-to-back frames, second start right behind the first valid
    ev_start(); send_bits(4'b0110, 4);
    gap = 1; ev_stop(); gap = 8;
    ev_start(); send_bits(4'b1100, 4); ev_stop();
    // restart inside a frame
    ev_start(); send_bits(2'b11, 2); ev_start(); send_bits(4'b0100, 4); ev_stop();

    // reset in the middle of a frame, bus returned to idle while held
    ev_start(); send_bits(3'b001, 3);
    @(negedge sclk);
    rst = 1'b0; scl = 1'b1; sda = 1'b1;
    open = 1'b0; bits.delete(); last_word = 0; have_good = 1'b0;
    repeat (3) @(posedge sclk);
    #1 check_reset_outputs();
    @(negedge sclk) rst = 1'b1;
    hold();
    ev_start(); send_bits(4'b0010, 4); ev_stop();

    // randomized link traffic
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      int          pick;
      r = $urandom_range(99, 0);
      if (open && bits.size() < NB)      pick = (r < 85) ? 0 : (sda ? 1 : 2);
      else if (open)                     pick = (!sda && r < 80) ? 2 : ((r < 50) ? 0 : (sda ? 1 : 2));
      else                               pick = (r < 60) ? (sda ? 1 : 2) : 0;
      case (pick)
        0:       ev_bit(int'($urandom_range(1, 0)));
        1:       ev_start();
        default: ev_stop();
      endcase
    end
    if (open) begin
      if (sda) ev_bit(0);
      ev_stop();
    end
    if (!sda) ev_start();
    if (open) begin ev_bit(0); ev_stop(); end

    repeat (20) @(posedge sclk);
    #2;
    check("valid_queue_drained", vq.size(), 0);
    check("err_queue_drained", eq.size(), 0);
    check("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sda_to_par.md
# sda_to_par

Serial-to-parallel receiver for the team's two-wire scl/sda link. It is the far end of the parallel-to-serial transmitter. It watches scl/sda, frames on start/stop conditions, shifts in NBITS data bits MSB first, and presents the word with a one-cycle valid strobe. It sits directly behind the link pins and feeds the display/decode logic.

## Interface
- NBITS, 4: data bits per frame.
- SYNC_STAGES, 2: synchronizer flops on scl and sda (minimum 2).
- sclk  in  1  receiver system clock; must run at least 8× the scl toggle rate.
- rst  in  1  reset, asynchronous, active-low.
- scl  in  1  link clock from transmitter, asynchronous to sclk.
- sda  in  1  link data from transmitter, asynchronous to sclk.
- data  out  NBITS  last good received word, MSB = first bit on the wire.
- valid  out  1  one-sclk pulse when data updates.
- frame_err  out  1  one-sclk pulse on a malformed frame.
- busy  out  1  high from start detect until frame completes or aborts.
- out16  out  2**NBITS  one-hot decode of data (see Configuration).

## Operation
- scl and sda each pass through SYNC_STAGES flops, then one history flop; all events use synchronized values (scl_s, sda_s).
- Event definitions:
  - start_det: sda_s falls while scl_s == 1.
  - stop_det: sda_s rises while scl_s == 1.
  - bit_det: scl_s rises; sample sda_s.
  - At most one event per cycle. When start_det/stop_det and bit_det coincide, bit_det wins.
- States:
  - IDLE: busy = 0. start_det → RECV, cnt = 0. All other events ignored.
  - RECV: bit_det → shreg = {shreg[NBITS-2:0], sda_s}, cnt++; on the NBITS-th bit → WAIT_STOP. stop_det → frame_err pulse, IDLE. start_det → frame_err pulse, RECV with cnt = 0 (restart).
  - WAIT_STOP: stop_det → data = shreg, valid pulse, IDLE. bit_det (extra bit) → frame_err pulse, IDLE. start_det → frame_err pulse, RECV with cnt = 0.
- data holds its value across error frames and idle; it changes only together with valid.
- cnt width is clog2(NBITS+1). cnt never wraps, because leaving RECV at cnt == NBITS is mandatory.

## Timing
- Reset values: data = 0, valid = 0, frame_err = 0, busy = 0, out16 = 0, state = IDLE, shreg = 0, cnt = 0. Synchronizer and history flops reset to 1 (idle-high bus), so a release from reset does not fire a false start.
- Detection latency: SYNC_STAGES + 1 sclk edges from a pin change to the event cycle.
- valid and data update are registered together, 1 sclk after the stop_det cycle. busy falls in the same cycle.
- frame_err is registered 1 sclk after the offending event.
- Reset asserted mid-frame: immediate return to reset values. The partial word is discarded and no valid or frame_err is produced.
- Back-to-back frames: a start_det in the cycle immediately after valid is accepted. IDLE is reachable in one cycle.

## Configuration
- DECODE16_EN defined: out16 is a registered one-hot of data. out16[data] = 1, updated in the same cycle as data. Reset value is 0; after the first valid frame exactly one bit is high.
- DECODE16_EN undefined: out16 is tied to 0 and no decode logic is built. The port remains, so integration is unchanged.

## Structure
- Package sda_link_pkg holds:
  - the state enum (IDLE, RECV, WAIT_STOP);
  - the NBITS default;
  - the idle bus level constant (1'b1).
  The transmitter uses the same package.
- Sub-module sync_edge: SYNC_STAGES synchronizer, history flop, and rise/fall outputs. It is instantiated once for scl and once for sda.

## Test plan
- Reset release with scl = sda = 1 → no events; all outputs 0; busy = 0.
- Frame: start, bits 1,0,1,1, stop → data = 4'b1011 with one valid pulse SYNC_STAGES+2 sclk after the stop edge. With DECODE16_EN, out16 = 16'h0800.
- Stop after 2 bits (1,0) → one frame_err pulse; data keeps its previous value; no valid.
- 5 bits before stop → frame_err on the 5th scl rise; the following stop is ignored in IDLE.
- Frame 4'b0110 immediately followed by frame 4'b1001 → two valid pulses; data = 4'b0110, then 4'b1001.
- rst asserted after bit 3 of a frame, released, then a full frame 4'b0001 → data = 4'b0001; no frame_err at any point.
